// File: rtl/sync_fifo_lvl_if.sv
// rtl/sync_fifo_lvl_if.sv - data/handshake/status bundle for sync_fifo_lvl
// Ports (slave = FIFO side):
//   fifo_in, fifo_wr_en, fifo_rd_en            : driven by master
//   fifo_out, fifo_out_vld, fifo_level,
//   fifo_full, fifo_empty, fifo_afull,
//   fifo_aempty, fifo_ovf, fifo_udf            : driven by slave
interface sync_fifo_lvl_if #(
    parameter int DW = 32,
    parameter int LW = 5
);
    logic [DW-1:0] fifo_in;
    logic          fifo_wr_en;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_out;
    logic          fifo_out_vld;
    logic [LW-1:0] fifo_level;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_afull;
    logic          fifo_aempty;
    logic          fifo_ovf;
    logic          fifo_udf;

    modport master (
        output fifo_in, fifo_wr_en, fifo_rd_en,
        input  fifo_out, fifo_out_vld, fifo_level, fifo_full, fifo_empty,
               fifo_afull, fifo_aempty, fifo_ovf, fifo_udf
    );

    modport slave (
        input  fifo_in, fifo_wr_en, fifo_rd_en,
        output fifo_out, fifo_out_vld, fifo_level, fifo_full, fifo_empty,
               fifo_afull, fifo_aempty, fifo_ovf, fifo_udf
    );
endinterface

// File: rtl/sync_fifo_lvl.sv
// rtl/sync_fifo_lvl.sv - single-clock FIFO, any depth, level/threshold/sticky flags
// Ports:
//   clk     : system clock
//   rst     : asynchronous reset, active-high
//   clk7_en : clock enable, all state advances only when high
//   clr     : synchronous flush, qualified by clk7_en
//   bus     : sync_fifo_lvl_if.slave (data, requests, output and status)
module sync_fifo_lvl #(
    parameter int FD   = 16,
    parameter int DW   = 32,
    parameter int AFT  = 14,
    parameter int AET  = 2,
    parameter bit FWFT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk7_en,
    input  logic                  clr,
    sync_fifo_lvl_if.slave        bus
);
    localparam int LW = $clog2(FD + 1);
    localparam int PW = ($clog2(FD) > 1) ? $clog2(FD) : 1;

    localparam logic [LW-1:0] LVL_FULL  = LW'(FD);
    localparam logic [LW-1:0] LVL_AFULL = LW'(AFT);
    localparam logic [LW-1:0] LVL_AEMPT = LW'(AET);
    localparam logic [PW-1:0] PTR_LAST  = PW'(FD - 1);

    logic [DW-1:0] mem [FD];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [LW-1:0] level;
    logic          ovf;
    logic          udf;

    logic full;
    logic empty;
    logic rd_acc;
    logic wr_acc;

    assign full  = (level == LVL_FULL);
    assign empty = (level == '0);

    // A full FIFO still takes a write when a read frees the slot in the same cycle.
    assign rd_acc = bus.fifo_rd_en & ~empty;
    assign wr_acc = bus.fifo_wr_en & (~full | rd_acc);

    assign bus.fifo_level  = level;
    assign bus.fifo_full   = full;
    assign bus.fifo_empty  = empty;
    assign bus.fifo_afull  = (level >= LVL_AFULL);
    assign bus.fifo_aempty = (level <= LVL_AEMPT);
    assign bus.fifo_ovf    = ovf;
    assign bus.fifo_udf    = udf;

    // Storage is not reset; only written on accepted, non-flushed writes.
    always_ff @(posedge clk) begin
        if (clk7_en && !clr && wr_acc) begin
            mem[wp] <= bus.fifo_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else if (clk7_en) begin
            if (clr) begin
                wp    <= '0;
                rp    <= '0;
                level <= '0;
                ovf   <= 1'b0;
                udf   <= 1'b0;
            end else begin
                // Explicit wrap so non-power-of-two depths work.
                if (wr_acc) begin
                    wp <= (wp == PTR_LAST) ? '0 : wp + 1'b1;
                end
                if (rd_acc) begin
                    rp <= (rp == PTR_LAST) ? '0 : rp + 1'b1;
                end
                case ({wr_acc, rd_acc})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: level <= level;
                endcase
                if (bus.fifo_wr_en && !wr_acc) begin
                    ovf <= 1'b1;
                end
                if (bus.fifo_rd_en && !rd_acc) begin
                    udf <= 1'b1;
                end
            end
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign bus.fifo_out     = mem[rp];
            assign bus.fifo_out_vld = ~empty;
        end else begin : g_reg
            logic [DW-1:0] out_q;
            logic          vld_q;

            // mem[rp] is sampled before this edge's write lands, so a
            // simultaneous read/write of the same slot returns the old word.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_q <= '0;
                    vld_q <= 1'b0;
                end else if (clk7_en) begin
                    if (clr) begin
                        vld_q <= 1'b0;
                    end else if (rd_acc) begin
                        out_q <= mem[rp];
                        vld_q <= 1'b1;
                    end else begin
                        vld_q <= 1'b0;
                    end
                end
            end

            assign bus.fifo_out     = out_q;
            assign bus.fifo_out_vld = vld_q;
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo_lvl.sv
// tb/tb_sync_fifo_lvl.sv - directed self-checking bench for sync_fifo_lvl (FWFT and registered)
module tb_sync_fifo_lvl;
    localparam int FD = 5;
    localparam int DW = 8;
    localparam int LW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk7_en = 1'b1;
    logic clr = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    sync_fifo_lvl_if #(.DW(DW), .LW(LW)) a_if ();
    sync_fifo_lvl_if #(.DW(DW), .LW(LW)) b_if ();

    sync_fifo_lvl #(.FD(FD), .DW(DW), .AFT(3), .AET(1), .FWFT(1'b1)) dut_a (
        .clk(clk), .rst(rst), .clk7_en(clk7_en), .clr(clr), .bus(a_if.slave)
    );

    sync_fifo_lvl #(.FD(FD), .DW(DW), .AFT(3), .AET(1), .FWFT(1'b0)) dut_b (
        .clk(clk), .rst(rst), .clk7_en(clk7_en), .clr(clr), .bus(b_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Level and status decode, identical for both instances.
    task automatic chk_st(input string tag, input int lvl, input bit ovf, input bit udf);
        chk({tag, " level"},  32'(a_if.fifo_level), 32'(lvl));
        chk({tag, " levelb"}, 32'(b_if.fifo_level), 32'(lvl));
        chk({tag, " full"},   32'(a_if.fifo_full),   32'(lvl == FD));
        chk({tag, " empty"},  32'(a_if.fifo_empty),  32'(lvl == 0));
        chk({tag, " afull"},  32'(a_if.fifo_afull),  32'(lvl >= 3));
        chk({tag, " aempty"}, 32'(a_if.fifo_aempty), 32'(lvl <= 1));
        chk({tag, " ovf"},    32'(a_if.fifo_ovf), 32'(ovf));
        chk({tag, " ovfb"},   32'(b_if.fifo_ovf), 32'(ovf));
        chk({tag, " udf"},    32'(a_if.fifo_udf), 32'(udf));
        chk({tag, " udfb"},   32'(b_if.fifo_udf), 32'(udf));
    endtask

    // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        a_if.fifo_wr_en = w; a_if.fifo_rd_en = r; a_if.fifo_in = d;
        b_if.fifo_wr_en = w; b_if.fifo_rd_en = r; b_if.fifo_in = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        a_if.fifo_wr_en = 1'b0; a_if.fifo_rd_en = 1'b0; a_if.fifo_in = '0;
        b_if.fifo_wr_en = 1'b0; b_if.fifo_rd_en = 1'b0; b_if.fifo_in = '0;
        repeat (2) @(negedge clk);

        chk_st("reset", 0, 1'b0, 1'b0);
        chk("reset vld_a", 32'(a_if.fifo_out_vld), 32'd0);
        chk("reset vld_b", 32'(b_if.fifo_out_vld), 32'd0);
        chk("reset out_b", 32'(b_if.fifo_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Three fill/drain passes: thresholds, order, pointer wrap.
        for (int p = 0; p < 3; p++) begin
            for (int i = 1; i <= FD; i++) begin
                cyc(1'b1, 1'b0, 8'(8'h11 * i));
                chk_st("fill", i, 1'b0, 1'b0);
                chk("fill head_a", 32'(a_if.fifo_out), 32'h11);
                chk("fill vld_a", 32'(a_if.fifo_out_vld), 32'd1);
            end
            for (int i = 1; i <= FD; i++) begin
                chk("drain head_a", 32'(a_if.fifo_out), 32'(8'(8'h11 * i)));
                cyc(1'b0, 1'b1, 8'h00);
                chk("drain out_b", 32'(b_if.fifo_out), 32'(8'(8'h11 * i)));
                chk("drain vld_b", 32'(b_if.fifo_out_vld), 32'd1);
                chk_st("drain", FD - i, 1'b0, 1'b0);
            end
            cyc(1'b0, 1'b0, 8'h00);
            chk("idle vld_b", 32'(b_if.fifo_out_vld), 32'd0);
            chk("idle vld_a", 32'(a_if.fifo_out_vld), 32'd0);
        end

        // Full: refused write, then simultaneous read+write.
        for (int i = 1; i <= FD; i++) cyc(1'b1, 1'b0, 8'(i));
        cyc(1'b1, 1'b0, 8'h66);
        chk_st("full wr", 5, 1'b1, 1'b0);
        chk("full wr head_a", 32'(a_if.fifo_out), 32'h01);
        cyc(1'b1, 1'b1, 8'h77);
        chk_st("full wr+rd", 5, 1'b1, 1'b0);
        chk("full wr+rd head_a", 32'(a_if.fifo_out), 32'h02);
        chk("full wr+rd out_b", 32'(b_if.fifo_out), 32'h01);
        begin
            logic [7:0] exp_q [5];
            exp_q = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h77};
            for (int i = 0; i < 5; i++) begin
                cyc(1'b0, 1'b1, 8'h00);
                chk("tail out_b", 32'(b_if.fifo_out), 32'(exp_q[i]));
            end
        end
        chk_st("tail done", 0, 1'b1, 1'b0);

        // Flush clears sticky flags, registered output holds its word.
        clr = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        clr = 1'b0;
        chk_st("clr", 0, 1'b0, 1'b0);
        chk("clr vld_b", 32'(b_if.fifo_out_vld), 32'd0);
        chk("clr out_b", 32'(b_if.fifo_out), 32'h77);

        // Empty: read refused, write accepted.
        cyc(1'b1, 1'b1, 8'hA5);
        chk_st("empty wr+rd", 1, 1'b0, 1'b1);
        chk("empty wr+rd out_a", 32'(a_if.fifo_out), 32'hA5);
        chk("empty wr+rd vld_a", 32'(a_if.fifo_out_vld), 32'd1);
        chk("empty wr+rd vld_b", 32'(b_if.fifo_out_vld), 32'd0);
        cyc(1'b0, 1'b1, 8'h00);
        chk("rd A5 out_b", 32'(b_if.fifo_out), 32'hA5);
        chk("rd A5 vld_b", 32'(b_if.fifo_out_vld), 32'd1);
        cyc(1'b0, 1'b0, 8'h00);
        chk("post idle vld_b", 32'(b_if.fifo_out_vld), 32'd0);
        chk("post idle out_b", 32'(b_if.fifo_out), 32'hA5);

        // Clock enable low: requests ignored, everything holds.
        cyc(1'b1, 1'b0, 8'h31);
        cyc(1'b1, 1'b0, 8'h32);
        cyc(1'b1, 1'b0, 8'h33);
        cyc(1'b0, 1'b1, 8'h00);
        chk("pre-hold out_b", 32'(b_if.fifo_out), 32'h31);
        clk7_en = 1'b0;
        repeat (3) cyc(1'b1, 1'b1, 8'hEE);
        chk_st("hold", 2, 1'b0, 1'b1);
        chk("hold vld_b", 32'(b_if.fifo_out_vld), 32'd1);
        chk("hold out_b", 32'(b_if.fifo_out), 32'h31);
        chk("hold out_a", 32'(a_if.fifo_out), 32'h32);
        clk7_en = 1'b1;

        // Flush beats a simultaneous read+write; slot 0 keeps 0xA5.
        cyc(1'b1, 1'b0, 8'h34);
        chk_st("pre-clr", 3, 1'b0, 1'b1);
        clr = 1'b1;
        cyc(1'b1, 1'b1, 8'h99);
        clr = 1'b0;
        chk_st("clr wr+rd", 0, 1'b0, 1'b0);
        chk("clr wr+rd mem0", 32'(a_if.fifo_out), 32'hA5);
        chk("clr wr+rd out_b", 32'(b_if.fifo_out), 32'h31);

        // Async reset in the middle of a burst.
        for (int i = 1; i <= 6; i++) cyc(1'b1, 1'b0, 8'(8'h80 + i));
        cyc(1'b0, 1'b1, 8'h00);
        chk_st("pre-rst", 4, 1'b1, 1'b0);
        chk("pre-rst out_b", 32'(b_if.fifo_out), 32'h81);
        a_if.fifo_wr_en = 1'b1; b_if.fifo_wr_en = 1'b1;
        a_if.fifo_in = 8'hC3;   b_if.fifo_in = 8'hC3;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk_st("async rst", 0, 1'b0, 1'b0);
        chk("async rst vld_b", 32'(b_if.fifo_out_vld), 32'd0);
        chk("async rst out_b", 32'(b_if.fifo_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sync_fifo_lvl.md
Name: sync_fifo_lvl

Overview:
Parametrised single-clock FIFO, successor to the basic sync FIFO used across chipset/DMA paths.
- Supports any depth (not only powers of two).
- Fill-level output, programmable almost-full/almost-empty flags, sticky overflow/underflow flags, synchronous flush.
- Selectable output mode: first-word-fall-through or registered read.
- All state advances only on enabled cycles of the 7 MHz clock enable.

Parameters:
FD, 16, FIFO depth in words; legal range FD >= 2, any integer.
DW, 32, data width in bits.
AFT, 14, almost-full threshold; fifo_afull when level >= AFT; legal 1..FD.
AET, 2, almost-empty threshold; fifo_aempty when level <= AET; legal 0..FD-1.
FWFT, 1, 1 = head word visible combinationally on fifo_out; 0 = fifo_out registered, updated by accepted read.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous reset, active-high.
clk7_en  in  1  clock enable; state changes only on rising clk with clk7_en=1.
clr  in  1  synchronous flush, qualified by clk7_en.
fifo_in  in  DW  write data.
fifo_wr_en  in  1  write request.
fifo_rd_en  in  1  read request.
fifo_out  out  DW  read data.
fifo_out_vld  out  1  fifo_out holds valid data.
fifo_level  out  clog2(FD+1)  number of stored words, 0..FD.
fifo_full  out  1  level == FD.
fifo_empty  out  1  level == 0.
fifo_afull  out  1  level >= AFT.
fifo_aempty  out  1  level <= AET.
fifo_ovf  out  1  sticky: write refused.
fifo_udf  out  1  sticky: read refused.

Behaviour:
- Reset (async, any time, including mid-operation):
  - wp, rp and level go to 0; empty=1, full=0, afull=0, aempty=1.
  - ovf=0, udf=0.
  - FWFT=0: fifo_out=0, fifo_out_vld=0.
  - Memory contents are not reset.
- Pointer width: max(1, clog2(FD)). Each pointer wraps explicitly from FD-1 to 0; no reliance on natural binary overflow.
- Define, per enabled cycle:
  - rd_acc = fifo_rd_en & !empty
  - wr_acc = fifo_wr_en & (!full | rd_acc)
  - A write to a full FIFO is accepted when a read is accepted in the same cycle.
- On wr_acc: mem[wp] <= fifo_in, then wp advances.
- On rd_acc: rp advances.
- Level update:
  - wr_acc only: +1.
  - rd_acc only: -1.
  - Both, or neither: unchanged.
  - Level never exceeds FD or goes below 0.
- Empty FIFO with rd_en and wr_en together: the read is refused (udf sets), the write is accepted, and level goes to 1.
- Status outputs full, empty, afull and aempty are combinational decodes of the level register, so they update in the same cycle the level changes.
- Sticky flags:
  - ovf sets on fifo_wr_en & !wr_acc.
  - udf sets on fifo_rd_en & !rd_acc.
  - Both remain set until clr or rst.
- clr (enabled cycle):
  - Highest priority; any wr/rd in the same cycle is ignored (no ovf/udf set).
  - Resets wp, rp, level, ovf, udf and fifo_out_vld; fifo_out keeps its value.
- FWFT=1 mode:
  - fifo_out = mem[rp], combinational.
  - fifo_out_vld = !empty.
  - A write into an empty FIFO appears on fifo_out after the enabled edge that stores it (0-cycle read latency after the write edge).
- FWFT=0 mode:
  - On rd_acc, fifo_out <= mem[rp] (pre-advance value) and fifo_out_vld <= 1.
  - On an enabled cycle without rd_acc, fifo_out_vld <= 0 and fifo_out holds.
  - Read latency is 1 enabled cycle.
  - Read and write at the same address when full return the old word.
- While clk7_en=0: no state changes; all outputs hold.

Test Plan:
- Reset → level=0, empty=1, aempty=1, full=0, ovf=0, udf=0, vld=0.
- FD=5: write 0x11..0x55, then read 5 → full=1 after 5th write, afull from level 3 (AFT=3); output order 0x11..0x55; wrap correct over 3 full passes.
- Full FIFO: wr only → ovf=1, level stays 5. wr+rd together → level stays 5, head advances, new word stored at tail.
- Empty FIFO: rd+wr together → udf=1, level=1. FWFT=1: fifo_out=written word next cycle, vld=1.
- FWFT=0: read with head 0xA5 → fifo_out=0xA5 and vld=1 one enabled cycle later; vld=0 after the next idle enabled cycle. clk7_en low 3 cycles → everything holds.
- clr asserted with wr+rd at level 3 → level=0, ovf=udf=0, no write stored. rst pulse mid-burst → immediate async clear.
